// File: rtl/mem_access_pkg.sv
// Shared access-size codes, FSM encoding and latched request payload.
package mem_access_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    WORD = 2'b00,
    HALF = 2'b01,
    BYTE = 2'b10
  } dtype_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    WR     = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Request fields captured when a transaction leaves IDLE.
  typedef struct packed {
    logic [1:0]      addr_lo;
    logic [1:0]      size;
    logic            uns;
    logic [XLEN-1:0] wdata;
  } req_t;

  // Code 2'b11 behaves as a word access.
  function automatic logic is_word(input logic [1:0] size);
    return (size != HALF) && (size != BYTE);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return (is_word(size) && (addr_lo != 2'b00)) || ((size == HALF) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]      i_addr_lo,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  input  logic [XLEN-1:0] i_rdata,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_load_c,
  output logic [XLEN-1:0] o_merge_c
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Select the addressed lane and sign/zero-extend it.
  always_comb begin
    w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    w_byte   = i_rdata[{i_addr_lo, 3'b000} +: 8];
    o_load_c = i_rdata;
    case (i_size)
      HALF:    o_load_c = i_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      BYTE:    o_load_c = i_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      default: o_load_c = i_rdata;
    endcase
  end

  // Overlay the store lane onto the word read from memory.
  always_comb begin
    o_merge_c = i_rdata;
    case (i_size)
      HALF: begin
        if (i_addr_lo[1]) o_merge_c[31:16] = i_wdata[15:0];
        else              o_merge_c[15:0]  = i_wdata[15:0];
      end
      BYTE:    o_merge_c[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      default: o_merge_c = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: stalls the pipeline, issues word accesses,
// performs read-modify-write for sub-word stores and extends sub-word loads.
module mem_access_ctrl
  import mem_access_pkg::*;
(
  input  logic            Clk,
  input  logic            Rst,
  input  logic            MEM_MemRead,
  input  logic            MEM_MemWrite,
  input  logic [XLEN-1:0] MEM_ALUResult,
  input  logic [XLEN-1:0] MEM_ReadData2,
  input  logic [1:0]      MEM_Datatype,
  input  logic            MEM_LoadUnsigned,
  output logic            Stall,
  output logic [XLEN-1:0] LoadData,
  output logic            LoadValid,
  output logic            Misaligned,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  state_e          r_state;
  state_e          w_next;
  req_t            r_lat;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic [XLEN-1:0] r_load_data;
  logic            r_load_valid;

  logic            w_req;
  logic            w_bad;
  logic            w_go;
  logic            w_stall;
  logic            w_misal;
  req_t            w_lat_d;
  logic            w_req_d;
  logic            w_we_d;
  logic [XLEN-1:0] w_addr_d;
  logic [XLEN-1:0] w_wdata_d;
  logic [XLEN-1:0] w_ld_d;
  logic            w_lv_d;
  logic [XLEN-1:0] w_load_c;
  logic [XLEN-1:0] w_merge_c;

  assign w_req = MEM_MemRead | MEM_MemWrite;
  assign w_bad = w_req & is_misaligned(MEM_Datatype, MEM_ALUResult[1:0]);
  assign w_go  = w_req & ~w_bad;

  mem_lane_align u_align (
    .i_addr_lo  (r_lat.addr_lo),
    .i_size     (r_lat.size),
    .i_unsigned (r_lat.uns),
    .i_rdata    (mem_rdata),
    .i_wdata    (r_lat.wdata),
    .o_load_c   (w_load_c),
    .o_merge_c  (w_merge_c)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; a simultaneous read and write is treated as a load.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          if (MEM_MemRead)             w_next = RD;
          else if (is_word(MEM_Datatype)) w_next = WR;
          else                         w_next = RMW_RD;
        end
      end
      RD:      if (mem_ready) w_next = DONE;
      RMW_RD:  if (mem_ready) w_next = RMW_WR;
      RMW_WR:  if (mem_ready) w_next = DONE;
      WR:      if (mem_ready) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic: combinational flags and next values of the registered outputs.
  always_comb begin
    w_stall   = 1'b0;
    w_misal   = 1'b0;
    w_lat_d   = r_lat;
    w_addr_d  = r_mem_addr;
    w_wdata_d = r_mem_wdata;
    w_ld_d    = r_load_data;
    w_lv_d    = 1'b0;
    w_req_d   = w_next inside {RD, RMW_RD, RMW_WR, WR};
    w_we_d    = w_next inside {RMW_WR, WR};
    case (r_state)
      IDLE: begin
        w_misal = w_bad;
        w_stall = w_go;
        if (w_go) begin
          w_lat_d   = '{addr_lo: MEM_ALUResult[1:0], size: MEM_Datatype,
                        uns: MEM_LoadUnsigned, wdata: MEM_ReadData2};
          w_addr_d  = {MEM_ALUResult[XLEN-1:2], 2'b00};
          w_wdata_d = MEM_ReadData2;
        end
      end
      RD: begin
        w_stall = 1'b1;
        if (mem_ready) begin
          w_ld_d = w_load_c;
          w_lv_d = 1'b1;
        end
      end
      RMW_RD: begin
        w_stall = 1'b1;
        if (mem_ready) w_wdata_d = w_merge_c;
      end
      RMW_WR:  w_stall = 1'b1;
      WR:      w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
  end

  // Registered outputs and latched request fields.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_lat        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
    end else begin
      r_lat        <= w_lat_d;
      r_mem_req    <= w_req_d;
      r_mem_we     <= w_we_d;
      r_mem_addr   <= w_addr_d;
      r_mem_wdata  <= w_wdata_d;
      r_load_data  <= w_ld_d;
      r_load_valid <= w_lv_d;
    end
  end

  assign Stall      = w_stall;
  assign Misaligned = w_misal;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign LoadData   = r_load_data;
  assign LoadValid  = r_load_valid;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of single transactions with
// mem_ready tied high, plus wait-state and mid-transaction reset sequences.
module tb_mem_access_ctrl;

  logic        Clk;
  logic        Rst;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [31:0] MEM_ALUResult;
  logic [31:0] MEM_ReadData2;
  logic [1:0]  MEM_Datatype;
  logic        MEM_LoadUnsigned;
  logic        Stall;
  logic [31:0] LoadData;
  logic        LoadValid;
  logic        Misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_tests;
  int n_fail;
  logic [31:0] exp_ld;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  dt;
    logic        uns;
    logic [31:0] rdata;
    logic        misal;
    int          stalls;
    logic [31:0] ld;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  mem_access_ctrl dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .MEM_MemRead      (MEM_MemRead),
    .MEM_MemWrite     (MEM_MemWrite),
    .MEM_ALUResult    (MEM_ALUResult),
    .MEM_ReadData2    (MEM_ReadData2),
    .MEM_Datatype     (MEM_Datatype),
    .MEM_LoadUnsigned (MEM_LoadUnsigned),
    .Stall            (Stall),
    .LoadData         (LoadData),
    .LoadValid        (LoadValid),
    .Misaligned       (Misaligned),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ready        (mem_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] dt, input logic uns,
                              input logic [31:0] rdata, input logic misal, input int stalls,
                              input logic [31:0] ld, input logic [31:0] maddr,
                              input logic [31:0] mwdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.dt = dt; v.uns = uns;
    v.rdata = rdata; v.misal = misal; v.stalls = stalls; v.ld = ld; v.maddr = maddr;
    v.mwdata = mwdata;
    return v;
  endfunction

  task automatic clear_inputs();
    MEM_MemRead      = 1'b0;
    MEM_MemWrite     = 1'b0;
    MEM_ALUResult    = 32'h0;
    MEM_ReadData2    = 32'h0;
    MEM_Datatype     = 2'b00;
    MEM_LoadUnsigned = 1'b0;
  endtask

  // Present one instruction, hold it while Stall=1, drop it after the DONE cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int          n_stall;
    int          n_req;
    int          n_lv;
    logic        seen_wr;
    logic        done;
    logic        exp_wr;
    logic [31:0] r_addr;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    n_stall = 0; n_req = 0; n_lv = 0; seen_wr = 1'b0; done = 1'b0;
    r_addr = 32'h0; w_addr = 32'h0; w_data = 32'h0;
    exp_wr = v.wr & ~v.rd & ~v.misal;
    @(posedge Clk); #1;
    MEM_MemRead      = v.rd;
    MEM_MemWrite     = v.wr;
    MEM_ALUResult    = v.addr;
    MEM_ReadData2    = v.wdata;
    MEM_Datatype     = v.dt;
    MEM_LoadUnsigned = v.uns;
    mem_rdata        = v.rdata;
    mem_ready        = 1'b1;
    @(negedge Clk);
    check($sformatf("v%0d misaligned", idx), 32'(Misaligned), 32'(v.misal));
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge Clk);
      if (mem_req) begin
        n_req++;
        r_addr = mem_addr;
        if (mem_we) begin
          seen_wr = 1'b1;
          w_addr  = mem_addr;
          w_data  = mem_wdata;
        end
      end
      if (LoadValid) n_lv++;
      if (!Stall) begin
        done = 1'b1;
        break;
      end
      n_stall++;
    end
    if (v.rd && !v.misal) exp_ld = v.ld;
    check($sformatf("v%0d done_in_budget", idx), 32'(done), 32'd1);
    check($sformatf("v%0d stall_cycles", idx), 32'(n_stall), 32'(v.stalls));
    check($sformatf("v%0d req_cycles", idx), 32'(n_req), v.misal ? 32'd0 : 32'(v.stalls - 1));
    check($sformatf("v%0d loadvalid_pulses", idx), 32'(n_lv), 32'(v.rd & ~v.misal));
    check($sformatf("v%0d loadvalid_done", idx), 32'(LoadValid), 32'(v.rd & ~v.misal));
    check($sformatf("v%0d load_data", idx), LoadData, exp_ld);
    check($sformatf("v%0d write_seen", idx), 32'(seen_wr), 32'(exp_wr));
    if (!v.misal) check($sformatf("v%0d mem_addr", idx), r_addr, v.maddr);
    if (exp_wr) begin
      check($sformatf("v%0d write_addr", idx), w_addr, v.maddr);
      check($sformatf("v%0d write_data", idx), w_data, v.mwdata);
    end
    @(posedge Clk); #1;
    clear_inputs();
    @(negedge Clk);
    check($sformatf("v%0d idle_stall", idx), 32'(Stall), 32'd0);
    check($sformatf("v%0d idle_req", idx), 32'(mem_req), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_ld  = 32'h0;

    //             rd wr addr          wdata         dt     u  rdata         mis st ld            maddr         mwdata
    vecs[0]  = mk(1, 0, 32'h0000_0100, 32'h0,        2'b00, 0, 32'hDEAD_BEEF, 0, 2, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0);
    vecs[1]  = mk(1, 0, 32'h0000_0103, 32'h0,        2'b10, 0, 32'h80FF_7F01, 0, 2, 32'hFFFF_FF80, 32'h0000_0100, 32'h0);
    vecs[2]  = mk(1, 0, 32'h0000_0103, 32'h0,        2'b10, 1, 32'h80FF_7F01, 0, 2, 32'h0000_0080, 32'h0000_0100, 32'h0);
    vecs[3]  = mk(1, 0, 32'h0000_0102, 32'h0,        2'b01, 0, 32'h80FF_7F01, 0, 2, 32'hFFFF_80FF, 32'h0000_0100, 32'h0);
    vecs[4]  = mk(1, 0, 32'h0000_0102, 32'h0,        2'b01, 1, 32'h80FF_7F01, 0, 2, 32'h0000_80FF, 32'h0000_0100, 32'h0);
    vecs[5]  = mk(1, 0, 32'h0000_0100, 32'h0,        2'b01, 0, 32'h80FF_7F01, 0, 2, 32'h0000_7F01, 32'h0000_0100, 32'h0);
    vecs[6]  = mk(1, 0, 32'h0000_0101, 32'h0,        2'b10, 0, 32'h80FF_7F01, 0, 2, 32'h0000_007F, 32'h0000_0100, 32'h0);
    vecs[7]  = mk(0, 1, 32'h0000_0202, 32'h0000_ABCD, 2'b01, 0, 32'h1122_3344, 0, 3, 32'h0,        32'h0000_0200, 32'hABCD_3344);
    vecs[8]  = mk(1, 0, 32'h0000_0102, 32'h0,        2'b10, 0, 32'h80FF_7F01, 0, 2, 32'hFFFF_FFFF, 32'h0000_0100, 32'h0);
    vecs[9]  = mk(0, 1, 32'h0000_0301, 32'h1234_56AA, 2'b10, 0, 32'h1122_3344, 0, 3, 32'h0,        32'h0000_0300, 32'h1122_AA44);
    vecs[10] = mk(0, 1, 32'h0000_0400, 32'hCAFE_F00D, 2'b00, 0, 32'h1122_3344, 0, 2, 32'h0,        32'h0000_0400, 32'hCAFE_F00D);
    vecs[11] = mk(0, 1, 32'h0000_0200, 32'hFFFF_5678, 2'b01, 0, 32'h1122_3344, 0, 3, 32'h0,        32'h0000_0200, 32'h1122_5678);
    vecs[12] = mk(1, 0, 32'h0000_0102, 32'h0,        2'b00, 0, 32'h1111_1111, 1, 0, 32'h0,        32'h0,         32'h0);
    vecs[13] = mk(1, 0, 32'h0000_0101, 32'h0,        2'b01, 0, 32'h1111_1111, 1, 0, 32'h0,        32'h0,         32'h0);
    vecs[14] = mk(0, 1, 32'h0000_0501, 32'h5555_5555, 2'b11, 0, 32'h1111_1111, 1, 0, 32'h0,        32'h0,         32'h0);
    vecs[15] = mk(1, 1, 32'h0000_0500, 32'h9999_9999, 2'b11, 0, 32'h1234_5678, 0, 2, 32'h1234_5678, 32'h0000_0500, 32'h0);
    vecs[16] = mk(0, 1, 32'h0000_0203, 32'h0000_00EE, 2'b10, 0, 32'h1122_3344, 0, 3, 32'h0,        32'h0000_0200, 32'hEE22_3344);

    // Reset state.
    Rst       = 1'b0;
    mem_rdata = 32'h0;
    mem_ready = 1'b1;
    clear_inputs();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst stall", 32'(Stall), 32'd0);
    check("rst misaligned", 32'(Misaligned), 32'd0);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst load_data", LoadData, 32'h0);
    check("rst load_valid", 32'(LoadValid), 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Word store held in WR by five wait cycles; inputs change underneath it.
    @(posedge Clk); #1;
    MEM_MemWrite  = 1'b1;
    MEM_ALUResult = 32'h0000_0600;
    MEM_ReadData2 = 32'h1357_9BDF;
    MEM_Datatype  = 2'b00;
    mem_ready     = 1'b0;
    @(negedge Clk);
    check("wait c0 stall", 32'(Stall), 32'd1);
    check("wait c0 mem_req", 32'(mem_req), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      if (i == 0) begin
        MEM_ALUResult = 32'h0000_7770;
        MEM_ReadData2 = 32'h0;
      end
      if (i == 5) mem_ready = 1'b1;
      @(negedge Clk);
      check($sformatf("wait c%0d mem_req", i + 1), 32'(mem_req), 32'd1);
      check($sformatf("wait c%0d mem_we", i + 1), 32'(mem_we), 32'd1);
      check($sformatf("wait c%0d mem_addr", i + 1), mem_addr, 32'h0000_0600);
      check($sformatf("wait c%0d mem_wdata", i + 1), mem_wdata, 32'h1357_9BDF);
      check($sformatf("wait c%0d stall", i + 1), 32'(Stall), 32'd1);
    end
    @(posedge Clk); #1;
    clear_inputs();
    @(negedge Clk);
    check("wait done stall", 32'(Stall), 32'd0);
    check("wait done mem_req", 32'(mem_req), 32'd0);
    check("wait done load_data", LoadData, exp_ld);

    // Reset asserted while a byte store sits in RMW_RD.
    @(posedge Clk); #1;
    MEM_MemWrite  = 1'b1;
    MEM_ALUResult = 32'h0000_0701;
    MEM_ReadData2 = 32'h0000_0055;
    MEM_Datatype  = 2'b10;
    mem_ready     = 1'b0;
    @(negedge Clk);
    check("rmwrst c0 stall", 32'(Stall), 32'd1);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("rmwrst c1 mem_req", 32'(mem_req), 32'd1);
    check("rmwrst c1 mem_we", 32'(mem_we), 32'd0);
    check("rmwrst c1 mem_addr", mem_addr, 32'h0000_0700);
    check("rmwrst pre load_data", LoadData, exp_ld);
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    check("rmwrst async mem_req", 32'(mem_req), 32'd0);
    check("rmwrst async load_data", LoadData, 32'h0);
    clear_inputs();
    exp_ld = 32'h0;
    @(negedge Clk);
    check("rmwrst mem_req", 32'(mem_req), 32'd0);
    check("rmwrst load_data", LoadData, 32'h0);
    check("rmwrst mem_addr", mem_addr, 32'h0);
    check("rmwrst mem_wdata", mem_wdata, 32'h0);
    check("rmwrst stall", 32'(Stall), 32'd0);
    @(posedge Clk); #1;
    Rst       = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check($sformatf("rmwrst post%0d stall", i), 32'(Stall), 32'd0);
      check($sformatf("rmwrst post%0d mem_req", i), 32'(mem_req), 32'd0);
      check($sformatf("rmwrst post%0d mem_we", i), 32'(mem_we), 32'd0);
    end

    // Normal operation after recovery.
    run_vec(100, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
